// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan decoder: active-low segment patterns,
// special digit codes and the scan FSM state type.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] CODE_BLANK = 4'hF;
   localparam logic [3:0] CODE_ERR   = 4'hE;

   typedef enum logic [1:0] {
      WAIT   = 2'd0,
      SETTLE = 2'd1,
      HELD   = 2'd2
   } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern decoder {g..a}, active-low, to a BCD code.
// Unknown patterns return CODE_ERR with err_o set.
module seg7_decode
   import seg_pkg::*;
(
   input  logic [6:0] pat_i,
   output logic [3:0] code_o,
   output logic       err_o
);

   always_comb begin
      code_o = CODE_ERR;
      err_o  = 1'b0;
      case (pat_i)
         SEG_0:     code_o = 4'd0;
         SEG_1:     code_o = 4'd1;
         SEG_2:     code_o = 4'd2;
         SEG_3:     code_o = 4'd3;
         SEG_4:     code_o = 4'd4;
         SEG_5:     code_o = 4'd5;
         SEG_6:     code_o = 4'd6;
         SEG_7:     code_o = 4'd7;
         SEG_8:     code_o = 4'd8;
         SEG_9:     code_o = 4'd9;
         SEG_BLANK: code_o = CODE_BLANK;
         default:   err_o  = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples multiplexed active-low an/seg scan lines, recovers the displayed digits
// and publishes them once a whole frame has repeated STABLE_FRAMES times.
//
//   state  | meaning
//   WAIT   | looking for a valid one-hot-low anode
//   SETTLE | anode held, counting down before seg is sampled
//   HELD   | position captured, waiting for the anode to move on
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int SETTLE_CYCLES  = 16,
   parameter int STABLE_FRAMES  = 2,
   parameter int TIMEOUT_CYCLES = 2**20
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            an,
   input  logic [7:0]            seg,
   output logic [4*DIGITS-1:0]   digits,
   output logic [DIGITS-1:0]     dp,
   output logic                  frame_valid,
   output logic                  pat_err,
   output logic                  stalled
);

   localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int SW = $clog2(STABLE_FRAMES + 1);
   localparam logic [7:0]        LOW_MASK = 8'((1 << DIGITS) - 1);
   localparam logic [DIGITS-1:0] FULL     = '1;

   logic [7:0]          an_s1_q, an_s2_q, an_prev_q, seg_s1_q, seg_s2_q;
   scan_state_e         state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [PW-1:0]       pos_q, pos_d, pos;
   logic [DIGITS-1:0]   mask_q, mask_d;
   logic [4*DIGITS-1:0] wcode_q, wcode_d, lcode_q, lcode_d, digits_q, digits_d;
   logic [DIGITS-1:0]   wdp_q, wdp_d, ldp_q, ldp_d, dp_q, dp_d;
   logic [SW-1:0]       stable_q, stable_d;
   logic [TW-1:0]       tmo_q, tmo_d;
   logic                fv_q, fv_d, pat_err_q, pat_err_d, stalled_q, stalled_d;
   logic                an_chg, an_valid, cap, tmo_evt, complete, pub;
   logic [3:0]          dec_code;
   logic                dec_err;

   assign an_chg   = (an_s2_q != an_prev_q);
   assign an_valid = ((an_s2_q | LOW_MASK) == 8'hFF) && $onehot(~an_s2_q & LOW_MASK);
   assign tmo_evt  = !an_chg && (tmo_q == TW'(1));
   assign complete = (mask_q == FULL);

   always_comb begin
      pos = '0;
      for (int i = 0; i < DIGITS; i++)
         if (!an_s2_q[i]) pos = PW'(i);
   end

   seg7_decode u_dec (
      .pat_i  (seg_s2_q[6:0]),
      .code_o (dec_code),
      .err_o  (dec_err)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pos_d   = pos_q;
      cap     = 1'b0;
      case (state_q)
         WAIT: begin
            if (an_valid) begin
               state_d = SETTLE;
               pos_d   = pos;
               cnt_d   = CW'(SETTLE_CYCLES - 1);
            end
         end
         SETTLE: begin
            if (an_chg) begin
               state_d = WAIT;
            end else if (cnt_q <= CW'(1)) begin
               cap     = 1'b1;
               state_d = HELD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         HELD: begin
            if (an_chg) state_d = WAIT;
         end
         default: state_d = WAIT;
      endcase
   end

   // Frame buffer, stability compare and publish; a timeout always empties the mask.
   always_comb begin
      mask_d    = mask_q;
      wcode_d   = wcode_q;
      wdp_d     = wdp_q;
      lcode_d   = lcode_q;
      ldp_d     = ldp_q;
      stable_d  = stable_q;
      digits_d  = digits_q;
      dp_d      = dp_q;
      fv_d      = 1'b0;
      pub       = 1'b0;
      pat_err_d = pat_err_q | (cap & dec_err);
      if (complete) begin
         mask_d = '0;
         if (!tmo_evt) begin
            if ({wcode_q, wdp_q} == {lcode_q, ldp_q}) begin
               if (stable_q < SW'(STABLE_FRAMES)) stable_d = stable_q + SW'(1);
               pub = (stable_q == SW'(STABLE_FRAMES - 1));
            end else begin
               stable_d = SW'(1);
               lcode_d  = wcode_q;
               ldp_d    = wdp_q;
               pub      = (STABLE_FRAMES == 1);
            end
            if (pub) begin
               digits_d = wcode_q;
               dp_d     = wdp_q;
               fv_d     = 1'b1;
            end
         end
      end
      if (cap) begin
         wcode_d[{pos_q, 2'b00} +: 4] = dec_code;
         wdp_d[pos_q]                 = ~seg_s2_q[7];
         mask_d[pos_q]                = 1'b1;
      end
      if (tmo_evt) mask_d = '0;
   end

   always_comb begin
      tmo_d     = tmo_q;
      stalled_d = stalled_q;
      if (an_chg) begin
         tmo_d     = TW'(TIMEOUT_CYCLES);
         stalled_d = 1'b0;
      end else begin
         if (tmo_q != '0) tmo_d = tmo_q - 1'b1;
         if (tmo_evt) stalled_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         an_s1_q   <= 8'hFF;
         an_s2_q   <= 8'hFF;
         an_prev_q <= 8'hFF;
         seg_s1_q  <= 8'hFF;
         seg_s2_q  <= 8'hFF;
         state_q   <= WAIT;
         cnt_q     <= '0;
         pos_q     <= '0;
         mask_q    <= '0;
         wcode_q   <= '1;
         wdp_q     <= '0;
         lcode_q   <= '1;
         ldp_q     <= '0;
         stable_q  <= '0;
         digits_q  <= '1;
         dp_q      <= '0;
         fv_q      <= 1'b0;
         pat_err_q <= 1'b0;
         tmo_q     <= TW'(TIMEOUT_CYCLES);
         stalled_q <= 1'b0;
      end else begin
         an_s1_q   <= an;
         an_s2_q   <= an_s1_q;
         an_prev_q <= an_s2_q;
         seg_s1_q  <= seg;
         seg_s2_q  <= seg_s1_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pos_q     <= pos_d;
         mask_q    <= mask_d;
         wcode_q   <= wcode_d;
         wdp_q     <= wdp_d;
         lcode_q   <= lcode_d;
         ldp_q     <= ldp_d;
         stable_q  <= stable_d;
         digits_q  <= digits_d;
         dp_q      <= dp_d;
         fv_q      <= fv_d;
         pat_err_q <= pat_err_d;
         tmo_q     <= tmo_d;
         stalled_q <= stalled_d;
      end
   end

   assign digits      = digits_q;
   assign dp          = dp_q;
   assign frame_valid = fv_q;
   assign pat_err     = pat_err_q;
   assign stalled     = stalled_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans, content change, glitches, bad
// patterns, mid-frame reset and anode stall, all with hand-derived expectations.
module tb_seg_scan_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  an, seg;
   logic [15:0] digits;
   logic [3:0]  dp;
   logic        frame_valid, pat_err, stalled;
   logic        fv_prev = 1'b0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          fv_cnt = 0;

   always #5 clk = ~clk;

   seg_scan_decoder #(
      .DIGITS(4), .SETTLE_CYCLES(16), .STABLE_FRAMES(2), .TIMEOUT_CYCLES(1000)
   ) dut (
      .clk(clk), .reset(reset), .an(an), .seg(seg),
      .digits(digits), .dp(dp), .frame_valid(frame_valid),
      .pat_err(pat_err), .stalled(stalled)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // frame_valid must be a single-cycle pulse
   always @(negedge clk) begin
      if (reset) begin
         fv_prev <= 1'b0;
      end else begin
         if (frame_valid) begin
            fv_cnt++;
            n_cmp++;
            assert (fv_prev !== 1'b1) else begin
               n_bad++;
               $error("FAIL fv_double: observed 1 expected 0");
            end
         end
         fv_prev <= frame_valid;
      end
   end

   function automatic logic [6:0] pat_of(input logic [3:0] c);
      case (c)
         4'h0: pat_of = 7'b1000000;
         4'h1: pat_of = 7'b1111001;
         4'h2: pat_of = 7'b0100100;
         4'h3: pat_of = 7'b0110000;
         4'h4: pat_of = 7'b0011001;
         4'h5: pat_of = 7'b0010010;
         4'h6: pat_of = 7'b0000010;
         4'h7: pat_of = 7'b1111000;
         4'h8: pat_of = 7'b0000000;
         4'h9: pat_of = 7'b0010000;
         4'hF: pat_of = 7'b1111111;
         default: pat_of = 7'b1010101;
      endcase
   endfunction

   task automatic dwell(input logic [7:0] an_v, input logic [7:0] seg_v, input int n);
      an  = an_v;
      seg = seg_v;
      repeat (n) @(negedge clk);
   endtask

   task automatic show(input int p, input logic [3:0] c, input logic d, input int n);
      logic [7:0] a;
      a = ~(8'h01 << p);
      dwell(a, {~d, pat_of(c)}, n);
   endtask

   task automatic scan(input logic [15:0] d, input logic [3:0] m, input int first, input int last);
      for (int p = first; p <= last; p++) show(p, d[4*p +: 4], m[p], 100);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_digits"}, digits, 16'hFFFF);
      check({tag, "_dp"}, dp, 4'h0);
      check({tag, "_fv"}, frame_valid, 1'b0);
      check({tag, "_pat_err"}, pat_err, 1'b0);
      check({tag, "_stalled"}, stalled, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      an    = 8'hFF;
      seg   = 8'hFF;
      repeat (4) @(negedge clk);
      check_reset_state("rst");
      reset = 1'b0;

      // 1: "1234" with dp on position 2
      scan(16'h1234, 4'b0100, 0, 3);
      check("t1_f1_no_pulse", fv_cnt, 0);
      scan(16'h1234, 4'b0100, 0, 3);
      check("t1_f2_pulse", fv_cnt, 1);
      check("t1_digits", digits, 16'h1234);
      check("t1_dp", dp, 4'b0100);
      scan(16'h1234, 4'b0100, 0, 3);
      check("t1_f3_no_repeat", fv_cnt, 1);

      // 2: content changes mid-scan
      scan(16'h1234, 4'b0100, 0, 1);
      scan(16'h0059, 4'b0000, 2, 3);
      check("t2_mixed", fv_cnt, 1);
      scan(16'h0059, 4'b0000, 0, 3);
      check("t2_f1", fv_cnt, 1);
      check("t2_digits_held", digits, 16'h1234);
      scan(16'h0059, 4'b0000, 0, 3);
      check("t2_f2_pulse", fv_cnt, 2);
      check("t2_digits", digits, 16'h0059);
      check("t2_dp", dp, 4'b0000);

      // 3: short glitch to an already-captured position, then a two-low anode
      scan(16'h0059, 4'b0000, 0, 2);
      show(0, 4'h8, 1'b0, 10);
      dwell(8'hFC, {1'b1, pat_of(4'h8)}, 100);
      scan(16'h0059, 4'b0000, 3, 3);
      scan(16'h0059, 4'b0000, 0, 3);
      scan(16'h0059, 4'b0000, 0, 3);
      check("t3_no_pulse", fv_cnt, 2);
      check("t3_digits", digits, 16'h0059);
      check("t3_pat_err", pat_err, 1'b0);

      // 4: blank on pos3, illegal pattern on pos1
      scan(16'hF0E9, 4'b0000, 0, 3);
      check("t4_pat_err_set", pat_err, 1'b1);
      scan(16'hF0E9, 4'b0000, 0, 3);
      check("t4_pulse", fv_cnt, 3);
      check("t4_digits", digits, 16'hF0E9);
      scan(16'h1234, 4'b0100, 0, 3);
      scan(16'h1234, 4'b0100, 0, 3);
      check("t4_pulse2", fv_cnt, 4);
      check("t4_digits2", digits, 16'h1234);
      check("t4_pat_err_sticky", pat_err, 1'b1);

      // 5: reset after three of four captures
      scan(16'h0059, 4'b0000, 0, 2);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_state("t5_rst");
      reset = 1'b0;
      scan(16'h0059, 4'b0000, 3, 3);
      scan(16'h0059, 4'b0000, 0, 3);
      check("t5_f1_no_pulse", fv_cnt, 4);
      check("t5_digits_reset", digits, 16'hFFFF);
      scan(16'h0059, 4'b0000, 0, 3);
      check("t5_f2_pulse", fv_cnt, 5);
      check("t5_digits", digits, 16'h0059);

      // 6: frozen anode -> stall, mask emptied, digits held
      show(0, 4'h7, 1'b0, 990);
      check("t6_not_yet", stalled, 1'b0);
      repeat (20) @(negedge clk);
      check("t6_stalled", stalled, 1'b1);
      check("t6_digits_held", digits, 16'h0059);
      show(1, 4'h5, 1'b0, 5);
      check("t6_unstalled", stalled, 1'b0);
      show(1, 4'h5, 1'b0, 95);
      scan(16'h0059, 4'b0000, 2, 3);
      scan(16'h0059, 4'b0000, 0, 3);
      scan(16'h0059, 4'b0000, 0, 3);
      check("t6_mask_cleared", fv_cnt, 5);
      check("t6_digits_final", digits, 16'h0059);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
